div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative unsigned divider; the inverse of the 3-lane 6x8 multiplier used in the CLAHE interpolation/normalization datapath.
- Divides LANES independent NUMW-bit numerators by DENW-bit denominators in parallel, producing quotient, remainder and divide-by-zero flags.
- Uses a valid/ready handshake on both sides, with clk_en gating identical to the multiplier's.
- Sits after the interpolation multiply-accumulate to normalize weighted sums back to pixel range.

Parameters:
- LANES, 3, number of parallel independent division lanes.
- NUMW, 14, numerator and quotient width in bits.
- DENW, 6, denominator and remainder width in bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- clk_en  input  1  clock enable; when low all state is frozen and no handshake completes.
- i_valid  input  1  upstream operands valid.
- o_ready  output  1  block can accept operands (high only in IDLE).
- i_num  input  LANES x NUMW  numerators, packed [LANES-1:0][NUMW-1:0].
- i_den  input  LANES x DENW  denominators.
- o_valid  output  1  results valid.
- i_ready  input  1  downstream accepts results.
- o_quot  output  LANES x NUMW  quotients.
- o_rem  output  LANES x DENW  remainders.
- o_dbz  output  LANES  per-lane divide-by-zero flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, iteration counter=0.
  - o_valid=0, o_ready=1 (after reset release), o_quot=0, o_rem=0, o_dbz=0.
- Handshake rules:
  - Input transfer = clk_en & i_valid & o_ready at a rising edge.
  - Output transfer = clk_en & o_valid & i_ready.
  - Operands are captured only on an input transfer. i_num/i_den are don't-care otherwise.
- FSM states:
  - IDLE: o_ready=1. On input transfer, latch num/den per lane, clear the partial remainder (DENW+1 bits), counter=NUMW-1, go to CALC.
  - CALC: o_ready=0. On each enabled edge, per lane, one restoring step:
    - r' = {r, num_msb}.
    - If r' >= den: r = r'-den and shift in quotient bit 1; else r = r' and shift in 0.
    - Counter decrements. On the edge where counter==0, go to DONE; the result registers load the same edge.
  - DONE: o_valid=1, outputs stable. On output transfer, go to IDLE and drop o_valid to 0 on that edge.
- Timing:
  - Latency: input transfer at edge E gives o_valid=1 after edge E+NUMW (counting enabled edges only).
  - Throughput: one operation per NUMW+2 enabled cycles minimum. No accept in DONE, even with a simultaneous output transfer.
- Arithmetic:
  - All unsigned. quot = floor(num/den), rem = num mod den; rem always fits DENW bits.
  - Lanes are fully independent; all lanes finish together.
- Divide by zero (den==0), per lane:
  - o_quot = all ones, o_rem = 0, o_dbz = 1. Other lanes are unaffected.
  - o_dbz=0 for every nonzero denominator.
- clk_en low in any state:
  - State, counter, datapath and outputs hold. o_valid/o_ready keep their levels, but no transfer is counted.
- Backpressure: with i_ready=0 in DONE, o_quot/o_rem/o_dbz hold indefinitely.
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values; the in-flight result is discarded.
- i_valid while not in IDLE is ignored; no queuing.

Optional Feature:
- Macro: DIV_ITER_ROUND_EN.
- Defined:
  - An extra state ROUND is inserted between CALC and DONE, so latency becomes NUMW+1.
  - Per lane, if 2*rem >= den, then quot = quot+1, saturating at all ones.
  - o_rem still reports the truncated remainder.
  - Divide-by-zero lanes bypass rounding.
- Undefined: truncating division, with no ROUND state and latency NUMW.

Test Plan:
- Lanes num=200/16383/0, den=7/1/5 -> after 14 enabled cycles o_valid=1; quot=28/16383/0, rem=4/0/0, dbz=000. With DIV_ITER_ROUND_EN: quot=29/16383/0 after 15 cycles.
- num=15, den=6 all lanes -> quot=2, rem=3. With DIV_ITER_ROUND_EN: quot=3 (tie rounds up).
- Lane1 den=0, num=1234 -> lane1 quot=16383, rem=0, dbz=1; lanes 0/2 (num=100, den=10) -> quot=10, rem=0, dbz=0.
- i_ready held 0 for 20 cycles after o_valid -> outputs stable, o_ready=0, new i_valid ignored. i_ready=1 -> o_valid=0 next cycle, o_ready=1.
- clk_en low for 5 cycles mid-CALC -> o_valid asserts exactly 5 cycles later than the unstalled run; result unchanged.
- rst_n pulsed low at CALC iteration 7 -> o_valid=0, o_ready=1 after release. A subsequent 63/63 yields quot=1, rem=0.

Source files
------------

// File: rtl/div_iter_if.sv
// Operand/result handshake bundle for the iterative divider.
// master drives operands and i_ready; slave is the divider.
interface div_iter_if #(
   parameter int LANES = 3,
   parameter int NUMW  = 14,
   parameter int DENW  = 6
);
   logic                       i_valid;
   logic                       o_ready;
   logic [LANES-1:0][NUMW-1:0] i_num;
   logic [LANES-1:0][DENW-1:0] i_den;
   logic                       o_valid;
   logic                       i_ready;
   logic [LANES-1:0][NUMW-1:0] o_quot;
   logic [LANES-1:0][DENW-1:0] o_rem;
   logic [LANES-1:0]           o_dbz;

   modport master (
      output i_valid, i_num, i_den, i_ready,
      input  o_ready, o_valid, o_quot, o_rem, o_dbz
   );

   modport slave (
      input  i_valid, i_num, i_den, i_ready,
      output o_ready, o_valid, o_quot, o_rem, o_dbz
   );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider, LANES parallel lanes, one quotient bit per enabled cycle.
// Define DIV_ITER_ROUND_EN to round quotients to nearest (ties up) via an extra ROUND state.
module div_iter_lane #(
   parameter int NUMW = 14,
   parameter int DENW = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            fin,
`ifdef DIV_ITER_ROUND_EN
   input  logic            rnd,
`endif
   input  logic [NUMW-1:0] num,
   input  logic [DENW-1:0] den,
   output logic [NUMW-1:0] quot,
   output logic [DENW-1:0] rem,
   output logic            dbz
);
   // num_sh shifts numerator bits out of the top and quotient bits in at the bottom
   logic [NUMW-1:0] num_sh;
   logic [DENW-1:0] den_r;
   logic [DENW:0]   r;
   logic [DENW+1:0] r_sh;
   logic [DENW:0]   r_nxt;
   logic            ge;
   logic            dz;

   assign r_sh  = {r, num_sh[NUMW-1]};
   assign ge    = r_sh >= {2'b00, den_r};
   // when ge holds with a nonzero divisor, r_sh < 2*den so its top bit is zero
   assign r_nxt = ge ? (r_sh[DENW:0] - {1'b0, den_r}) : r_sh[DENW:0];
   assign dz    = (den_r == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_sh <= '0;
         den_r  <= '0;
         r      <= '0;
         quot   <= '0;
         rem    <= '0;
         dbz    <= 1'b0;
      end else begin
         if (load) begin
            num_sh <= num;
            den_r  <= den;
            r      <= '0;
         end else if (step) begin
            num_sh <= {num_sh[NUMW-2:0], ge};
            r      <= r_nxt;
         end
         if (fin) begin
            quot <= dz ? '1 : {num_sh[NUMW-2:0], ge};
            rem  <= dz ? '0 : r_nxt[DENW-1:0];
            dbz  <= dz;
         end
`ifdef DIV_ITER_ROUND_EN
         if (rnd && !dbz && ({rem, 1'b0} >= {1'b0, den_r}) && (quot != '1))
            quot <= quot + NUMW'(1);
`endif
      end
   end
endmodule

module div_iter #(
   parameter int LANES = 3,
   parameter int NUMW  = 14,
   parameter int DENW  = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   div_iter_if.slave  bus
);
   localparam int CW = (NUMW > 1) ? $clog2(NUMW) : 1;

`ifdef DIV_ITER_ROUND_EN
   typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

   state_t  state, nxt;
   logic [CW-1:0] cnt;
   logic    load, step, fin;
   logic [LANES-1:0][NUMW-1:0] quot_w;
   logic [LANES-1:0][DENW-1:0] rem_w;
   logic [LANES-1:0]           dbz_w;

   assign load = clk_en & bus.i_valid & (state == IDLE);
   assign step = clk_en & (state == CALC);
   assign fin  = step & (cnt == '0);
`ifdef DIV_ITER_ROUND_EN
   logic rnd;
   assign rnd = clk_en & (state == ROUND);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (load)
            cnt <= CW'(NUMW - 1);
         else if (step && !fin)
            cnt <= cnt - CW'(1);
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (clk_en && bus.i_valid) nxt = CALC;
`ifdef DIV_ITER_ROUND_EN
         CALC:  if (fin)    nxt = ROUND;
         ROUND: if (clk_en) nxt = DONE;
`else
         CALC:  if (fin)    nxt = DONE;
`endif
         DONE: if (clk_en && bus.i_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign bus.o_ready = (state == IDLE);
   assign bus.o_valid = (state == DONE);
   assign bus.o_quot  = quot_w;
   assign bus.o_rem   = rem_w;
   assign bus.o_dbz   = dbz_w;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      div_iter_lane #(.NUMW(NUMW), .DENW(DENW)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .step  (step),
         .fin   (fin),
`ifdef DIV_ITER_ROUND_EN
         .rnd   (rnd),
`endif
         .num   (bus.i_num[g]),
         .den   (bus.i_den[g]),
         .quot  (quot_w[g]),
         .rem   (rem_w[g]),
         .dbz   (dbz_w[g])
      );
   end
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vectors plus randomized ops against an arithmetic model.
module tb_div_iter;
   localparam int LANES = 3;
   localparam int NUMW  = 14;
   localparam int DENW  = 6;
`ifdef DIV_ITER_ROUND_EN
   localparam int LAT = NUMW + 1;
`else
   localparam int LAT = NUMW;
`endif
   localparam int PER = LAT + 2;

   typedef logic [LANES-1:0][NUMW-1:0] numv_t;
   typedef logic [LANES-1:0][DENW-1:0] denv_t;
   typedef logic [LANES-1:0]           lanev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b1;
   int   checks = 0;
   int   errors = 0;

   div_iter_if #(.LANES(LANES), .NUMW(NUMW), .DENW(DENW)) bus ();

   div_iter #(.LANES(LANES), .NUMW(NUMW), .DENW(DENW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // floor division / modulo, optional round-half-up with saturation
   function automatic void model(input numv_t n, input denv_t d,
                                 output numv_t q, output denv_t r, output lanev_t z);
      int qq, rr;
      for (int l = 0; l < LANES; l++) begin
         if (d[l] == '0) begin
            q[l] = '1; r[l] = '0; z[l] = 1'b1;
         end else begin
            qq = int'(n[l]) / int'(d[l]);
            rr = int'(n[l]) % int'(d[l]);
`ifdef DIV_ITER_ROUND_EN
            if (2 * rr >= int'(d[l]) && qq < (1 << NUMW) - 1) qq++;
`endif
            q[l] = NUMW'(qq); r[l] = DENW'(rr); z[l] = 1'b0;
         end
      end
   endfunction

   function automatic numv_t rnd_num();
      numv_t n;
      for (int l = 0; l < LANES; l++)
         n[l] = ($urandom_range(0, 3) == 0) ? NUMW'($urandom_range(0, 200)) : NUMW'($urandom);
      return n;
   endfunction

   function automatic denv_t rnd_den();
      denv_t d;
      for (int l = 0; l < LANES; l++)
         d[l] = ($urandom_range(0, 7) == 0) ? '0 : DENW'($urandom_range(1, (1 << DENW) - 1));
      return d;
   endfunction

   task automatic start_op(input numv_t n, input denv_t d);
      int t = 0;
      while (!bus.o_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!bus.o_ready) begin
         checks++; errors++;
         $display("FAIL start_timeout: o_ready=%b after %0d cycles, need 1", bus.o_ready, t);
      end
      bus.i_num = n; bus.i_den = d; bus.i_valid = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      bus.i_num = rnd_num(); bus.i_den = rnd_den();
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      if (!bus.o_valid) begin
         checks++; errors++;
         $display("FAIL valid_timeout: o_valid=%b after %0d cycles, need 1", bus.o_valid, lat);
      end
   endtask

   task automatic consume();
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_quot !== '0 || bus.o_rem !== '0 || bus.o_dbz !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b quot=%h rem=%h dbz=%b, need all zero",
                  bus.o_valid, bus.o_quot, bus.o_rem, bus.o_dbz);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b valid=%b, need 1/0", bus.o_ready, bus.o_valid);
      end
   endtask

   task automatic test_vectors();
      numv_t n, eq; denv_t d, er; lanev_t ez; int lat;
      // 200/7, 16383/1, 0/5
      n[0] = 14'd200; n[1] = 14'd16383; n[2] = 14'd0;
      d[0] = 6'd7;    d[1] = 6'd1;      d[2] = 6'd5;
`ifdef DIV_ITER_ROUND_EN
      eq[0] = 14'd29;
`else
      eq[0] = 14'd28;
`endif
      eq[1] = 14'd16383; eq[2] = 14'd0;
      er[0] = 6'd4; er[1] = 6'd0; er[2] = 6'd0;
      start_op(n, d);
      wait_valid(lat);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL vec1_latency: got %0d, need %0d", lat, LAT); end
      checks++;
      if (bus.o_quot !== eq || bus.o_rem !== er || bus.o_dbz !== 3'b000) begin
         errors++;
         $display("FAIL vec1_result: quot=%h rem=%h dbz=%b, need %h %h 000",
                  bus.o_quot, bus.o_rem, bus.o_dbz, eq, er);
      end
      consume();

      // 15/6 on all lanes: exact half remainder
      n = {LANES{14'd15}}; d = {LANES{6'd6}};
`ifdef DIV_ITER_ROUND_EN
      eq = {LANES{14'd3}};
`else
      eq = {LANES{14'd2}};
`endif
      er = {LANES{6'd3}};
      start_op(n, d);
      wait_valid(lat);
      checks++;
      if (bus.o_quot !== eq || bus.o_rem !== er || bus.o_dbz !== 3'b000) begin
         errors++;
         $display("FAIL tie_result: quot=%h rem=%h dbz=%b, need %h %h 000",
                  bus.o_quot, bus.o_rem, bus.o_dbz, eq, er);
      end
      consume();

      // lane 1 divides by zero, lanes 0/2 are 100/10
      n[0] = 14'd100; n[1] = 14'd1234; n[2] = 14'd100;
      d[0] = 6'd10;   d[1] = 6'd0;     d[2] = 6'd10;
      eq[0] = 14'd10; eq[1] = 14'd16383; eq[2] = 14'd10;
      er = '0;
      start_op(n, d);
      wait_valid(lat);
      checks++;
      if (bus.o_quot !== eq || bus.o_rem !== er || bus.o_dbz !== 3'b010) begin
         errors++;
         $display("FAIL dbz_result: quot=%h rem=%h dbz=%b, need %h %h 010",
                  bus.o_quot, bus.o_rem, bus.o_dbz, eq, er);
      end
      consume();
   endtask

   task automatic test_random();
      numv_t n, eq; denv_t d, er; lanev_t ez; int lat;
      for (int k = 0; k < 40; k++) begin
         n = rnd_num(); d = rnd_den();
         if (k == 0) begin n = '1; d = {LANES{6'd63}}; end
         if (k == 1) begin n = '1; d = {LANES{6'd2}}; end
         model(n, d, eq, er, ez);
         start_op(n, d);
         wait_valid(lat);
         checks++;
         if (lat !== LAT || bus.o_quot !== eq || bus.o_rem !== er || bus.o_dbz !== ez) begin
            errors++;
            $display("FAIL random_%0d: lat=%0d quot=%h rem=%h dbz=%b, need %0d %h %h %b (num=%h den=%h)",
                     k, lat, bus.o_quot, bus.o_rem, bus.o_dbz, LAT, eq, er, ez, n, d);
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      numv_t n, eq; denv_t d, er; lanev_t ez; int lat;
      n = rnd_num(); d = rnd_den();
      model(n, d, eq, er, ez);
      start_op(n, d);
      wait_valid(lat);
      for (int c = 0; c < 20; c++) begin
         bus.i_valid = 1'b1; bus.i_num = rnd_num(); bus.i_den = rnd_den();
         @(posedge clk); #1;
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_quot !== eq ||
             bus.o_rem !== er || bus.o_dbz !== ez) begin
            errors++;
            $display("FAIL hold_%0d: valid=%b ready=%b quot=%h rem=%h dbz=%b, need 1 0 %h %h %b",
                     c, bus.o_valid, bus.o_ready, bus.o_quot, bus.o_rem, bus.o_dbz, eq, er, ez);
         end
      end
      // i_valid still high on the draining edge must not be accepted
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0; bus.i_valid = 1'b0;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain: valid=%b ready=%b, need 0 1", bus.o_valid, bus.o_ready);
      end
   endtask

   task automatic test_stall();
      numv_t n, eq; denv_t d, er; lanev_t ez; int lat;
      n = rnd_num(); d = rnd_den();
      model(n, d, eq, er, ez);
      start_op(n, d);
      lat = 0;
      while (!bus.o_valid && lat < 200) begin
         clk_en = (lat >= 6 && lat < 11) ? 1'b0 : 1'b1;
         @(posedge clk); #1; lat++;
      end
      clk_en = 1'b1;
      checks++;
      if (lat !== LAT + 5) begin errors++; $display("FAIL stall_latency: got %0d, need %0d", lat, LAT + 5); end
      checks++;
      if (bus.o_quot !== eq || bus.o_rem !== er || bus.o_dbz !== ez) begin
         errors++;
         $display("FAIL stall_result: quot=%h rem=%h dbz=%b, need %h %h %b",
                  bus.o_quot, bus.o_rem, bus.o_dbz, eq, er, ez);
      end
      // disabled clock in DONE: no output transfer even with i_ready high
      clk_en = 1'b0; bus.i_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_quot !== eq) begin
         errors++;
         $display("FAIL gated_done: valid=%b quot=%h, need 1 %h", bus.o_valid, bus.o_quot, eq);
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL gated_release: valid=%b ready=%b, need 0 1", bus.o_valid, bus.o_ready);
      end
   endtask

   task automatic test_reset_mid();
      numv_t n; denv_t d; int lat;
      n = {LANES{14'd9999}}; d = {LANES{6'd3}};
      start_op(n, d);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_quot !== '0 || bus.o_rem !== '0 ||
          bus.o_dbz !== '0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b ready=%b quot=%h rem=%h dbz=%b, need 0 1 0 0 0",
                  bus.o_valid, bus.o_ready, bus.o_quot, bus.o_rem, bus.o_dbz);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset: valid=%b ready=%b, need 0 1", bus.o_valid, bus.o_ready);
      end
      start_op({LANES{14'd63}}, {LANES{6'd63}});
      wait_valid(lat);
      checks++;
      if (lat !== LAT || bus.o_quot !== {LANES{14'd1}} || bus.o_rem !== '0 || bus.o_dbz !== '0) begin
         errors++;
         $display("FAIL post_reset_op: lat=%0d quot=%h rem=%h dbz=%b, need %0d quot=1 rem=0 dbz=0",
                  lat, bus.o_quot, bus.o_rem, bus.o_dbz, LAT);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      numv_t n, eq; denv_t d, er; lanev_t ez; int lat, gap;
      n = rnd_num(); d = rnd_den();
      model(n, d, eq, er, ez);
      bus.i_num = n; bus.i_den = d; bus.i_valid = 1'b1; bus.i_ready = 1'b1;
      wait_valid(lat);
      for (int k = 0; k < 3; k++) begin
         gap = 0;
         do begin @(posedge clk); #1; gap++; end while (!bus.o_valid && gap < 100);
         checks++;
         if (gap !== PER || bus.o_quot !== eq || bus.o_rem !== er || bus.o_dbz !== ez) begin
            errors++;
            $display("FAIL b2b_%0d: period=%0d quot=%h rem=%h dbz=%b, need %0d %h %h %b",
                     k, gap, bus.o_quot, bus.o_rem, bus.o_dbz, PER, eq, er, ez);
         end
      end
      bus.i_valid = 1'b0;
      @(posedge clk); #1;
      while (!bus.o_ready && gap < 200) begin @(posedge clk); #1; gap++; end
      bus.i_ready = 1'b0;
   endtask

   initial begin
      bus.i_valid = 1'b0; bus.i_ready = 1'b0;
      bus.i_num = '0; bus.i_den = '0;
      test_reset();
      test_vectors();
      test_random();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
